// File: rtl/timer_ctrl.sv
// timer_ctrl
//   Sequencing controller for the 64-bit timer counter datapath. Produces the
//   per-cycle increment enable from a power-of-two prescaler, runs the
//   debug-halt handshake, emits the clear pulse on disable and owns the
//   sticky compare-match interrupt status.
//
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   timer_en    in   timer enable
//   div_en      in   prescaler enable
//   div_val     in   prescale exponent (ratio 2^div_val, clamped to DIV_MAX)
//   dbg_mode    in   debug mode qualifier for halt
//   halt_req    in   halt request from debug logic
//   cnt         in   current counter value
//   cmp         in   compare value
//   int_en      in   interrupt enable
//   int_st_clr  in   write-1-to-clear pulse for int_st
//   cnt_en      out  counter increment enable
//   cnt_clr     out  one-cycle counter clear pulse
//   halt_ack    out  halt acknowledge (registered)
//   int_st      out  sticky compare-match status
//   tim_int     out  interrupt = int_st & int_en
//
// Halt FSM
//   state   | meaning
//   RUN     | counting allowed (subject to timer_en / prescaler)
//   HALTED  | debug halt acknowledged, counting frozen, div_cnt held

module timer_ctrl #(
    parameter int DIV_W   = 4,
    parameter int DIV_MAX = 8,
    parameter int CNT_W   = 64
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             timer_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             dbg_mode,
    input  logic             halt_req,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] cmp,
    input  logic             int_en,
    input  logic             int_st_clr,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             halt_ack,
    output logic             int_st,
    output logic             tim_int
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } halt_state_t;

    halt_state_t      state;
    logic [7:0]       div_cnt;
    logic             timer_en_q;
    logic [DIV_W:0]   div_cfg_q;

    logic [DIV_W-1:0] div_exp;
    logic [7:0]       div_limit;
    logic             bypass;
    logic             active;
    logic             cfg_chg;

    always_comb begin
        div_exp = (div_val > DIV_W'(DIV_MAX)) ? DIV_W'(DIV_MAX) : div_val;
        // 9-bit intermediate so that 2^8 - 1 = 255 still fits the 8-bit counter
        div_limit = 8'((9'd1 << div_exp) - 9'd1);
        bypass    = ~div_en | (div_exp == '0);
        active    = timer_en & ~halt_ack;
        cfg_chg   = ({div_en, div_val} != div_cfg_q);
        // A config change still uses the new limit against the old div_cnt
        cnt_en    = active & (bypass | (div_cnt == div_limit));
        cnt_clr   = timer_en_q & ~timer_en;
        tim_int   = int_st & int_en;
    end

    // Halt handshake: one cycle of latency in each direction
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= RUN;
            halt_ack <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (dbg_mode & halt_req) begin
                        state    <= HALTED;
                        halt_ack <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!(dbg_mode & halt_req)) begin
                        state    <= RUN;
                        halt_ack <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    halt_ack <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler; disable wins over halt, halt holds mid-period
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt    <= 8'd0;
            timer_en_q <= 1'b0;
            div_cfg_q  <= '0;
        end else begin
            timer_en_q <= timer_en;
            div_cfg_q  <= {div_en, div_val};
            if (!timer_en || cfg_chg) begin
                div_cnt <= 8'd0;
            end else if (active) begin
                if (cnt_en) begin
                    div_cnt <= 8'd0;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

    // Sticky compare status; set wins over clear
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            int_st <= 1'b0;
        end else if (cnt == cmp) begin
            int_st <= 1'b1;
        end else if (int_st_clr) begin
            int_st <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl
//   Directed bench for timer_ctrl. Inputs change 1 time unit after the rising
//   edge; outputs are observed on the falling edge of the same cycle.

module tb_timer_ctrl;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        timer_en;
    logic        div_en;
    logic [3:0]  div_val;
    logic        dbg_mode;
    logic        halt_req;
    logic [63:0] cnt;
    logic [63:0] cmp;
    logic        int_en;
    logic        int_st_clr;
    logic        cnt_en;
    logic        cnt_clr;
    logic        halt_ack;
    logic        int_st;
    logic        tim_int;

    int n_cmp;
    int n_bad;

    timer_ctrl #(.DIV_W(4), .DIV_MAX(8), .CNT_W(64)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .timer_en   (timer_en),
        .div_en     (div_en),
        .div_val    (div_val),
        .dbg_mode   (dbg_mode),
        .halt_req   (halt_req),
        .cnt        (cnt),
        .cmp        (cmp),
        .int_en     (int_en),
        .int_st_clr (int_st_clr),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .halt_ack   (halt_ack),
        .int_st     (int_st),
        .tim_int    (tim_int)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle's input-drive point
    task automatic adv();
        @(posedge sys_clk);
        #1;
    endtask

    // Move to the current cycle's observation point
    task automatic obs_pt();
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst_n  = 1'b0;
        timer_en   = 1'b0;
        div_en     = 1'b0;
        div_val    = 4'd0;
        dbg_mode   = 1'b0;
        halt_req   = 1'b0;
        cnt        = 64'd0;
        cmp        = 64'hFFFF_FFFF_FFFF_FFFF;
        int_en     = 1'b0;
        int_st_clr = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        adv();
    endtask

    initial begin
        int pulses;
        int first;

        n_cmp = 0;
        n_bad = 0;

        // Reset state
        do_reset();
        obs_pt();
        check_val("rst_cnt_en", cnt_en, 0);
        check_val("rst_cnt_clr", cnt_clr, 0);
        check_val("rst_halt_ack", halt_ack, 0);
        check_val("rst_int_st", int_st, 0);
        check_val("rst_tim_int", tim_int, 0);

        // Bypass: 10 cycles -> 10 pulses
        adv();
        timer_en = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            obs_pt();
            if (cnt_en) pulses++;
            adv();
        end
        check_val("bypass_pulses", pulses, 10);

        // Prescale by 4: pulses on active cycles 4, 8, 12
        do_reset();
        div_en  = 1'b1;
        div_val = 4'd2;
        adv();
        timer_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            obs_pt();
            check_val($sformatf("div4_c%0d", i), cnt_en, (i % 4 == 0) ? 1 : 0);
            adv();
        end

        // div_val=15 clamps to 8: first pulse on cycle 256, two pulses in 512
        do_reset();
        div_en  = 1'b1;
        div_val = 4'd15;
        adv();
        timer_en = 1'b1;
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 512; i++) begin
            obs_pt();
            if (cnt_en) begin
                pulses++;
                if (first == 0) first = i;
            end
            adv();
        end
        check_val("clamp_first", first, 256);
        check_val("clamp_pulses", pulses, 2);

        // Halt mid-period: 2 active cycles, 3 halted, resume needs 2 more
        do_reset();
        div_en   = 1'b1;
        div_val  = 4'd2;
        dbg_mode = 1'b1;
        adv();
        timer_en = 1'b1;
        obs_pt();
        check_val("halt_c1_en", cnt_en, 0);
        adv();
        halt_req = 1'b1;
        obs_pt();
        check_val("halt_c2_en", cnt_en, 0);
        check_val("halt_c2_ack", halt_ack, 0);
        for (int i = 0; i < 3; i++) begin
            adv();
            if (i == 2) halt_req = 1'b0;
            obs_pt();
            check_val($sformatf("halted%0d_ack", i), halt_ack, 1);
            check_val($sformatf("halted%0d_en", i), cnt_en, 0);
        end
        adv();
        obs_pt();
        check_val("resume1_ack", halt_ack, 0);
        check_val("resume1_en", cnt_en, 0);
        adv();
        obs_pt();
        check_val("resume2_en", cnt_en, 1);

        // Halt request without debug mode is ignored
        do_reset();
        timer_en = 1'b1;
        halt_req = 1'b1;
        pulses   = 0;
        for (int i = 0; i < 4; i++) begin
            obs_pt();
            check_val($sformatf("nodbg%0d_ack", i), halt_ack, 0);
            if (cnt_en) pulses++;
            adv();
        end
        check_val("nodbg_pulses", pulses, 4);

        // Disable: one-cycle clear, then re-enable with div_val=3
        do_reset();
        timer_en = 1'b1;
        adv();
        adv();
        timer_en = 1'b0;
        obs_pt();
        check_val("dis_clr", cnt_clr, 1);
        check_val("dis_en", cnt_en, 0);
        adv();
        div_en  = 1'b1;
        div_val = 4'd3;
        obs_pt();
        check_val("dis2_clr", cnt_clr, 0);
        check_val("dis2_en", cnt_en, 0);
        adv();
        timer_en = 1'b1;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            obs_pt();
            if (cnt_en && first == 0) first = i;
            adv();
        end
        check_val("reen_first", first, 8);

        // Disable while halted still pulses cnt_clr, halt unaffected
        do_reset();
        timer_en = 1'b1;
        dbg_mode = 1'b1;
        halt_req = 1'b1;
        adv();
        timer_en = 1'b0;
        obs_pt();
        check_val("hdis_ack", halt_ack, 1);
        check_val("hdis_clr", cnt_clr, 1);

        // Interrupt status
        do_reset();
        cmp    = 64'h0000_0000_0000_0005;
        cnt    = 64'd4;
        int_en = 1'b1;
        obs_pt();
        check_val("int_pre", int_st, 0);
        adv();
        cnt = 64'd5;
        obs_pt();
        check_val("int_match_cyc", int_st, 0);
        adv();
        obs_pt();
        check_val("int_set", int_st, 1);
        check_val("int_tim_en", tim_int, 1);
        int_en = 1'b0;
        #1;
        check_val("int_tim_mask", tim_int, 0);
        check_val("int_st_masked", int_st, 1);
        adv();
        int_st_clr = 1'b1;
        adv();
        int_st_clr = 1'b0;
        cnt = 64'd6;
        obs_pt();
        check_val("int_set_wins", int_st, 1);
        adv();
        int_st_clr = 1'b1;
        adv();
        int_st_clr = 1'b0;
        obs_pt();
        check_val("int_cleared", int_st, 0);

        // Async reset mid-operation drops pending halt and status
        do_reset();
        timer_en = 1'b1;
        dbg_mode = 1'b1;
        halt_req = 1'b1;
        cmp = 64'd0;
        cnt = 64'd0;
        adv();
        obs_pt();
        check_val("pre_rst_ack", halt_ack, 1);
        check_val("pre_rst_int", int_st, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_val("arst_ack", halt_ack, 0);
        check_val("arst_int", int_st, 0);
        check_val("arst_en", cnt_en, 1);
        adv();
        sys_rst_n = 1'b1;
        halt_req  = 1'b0;
        adv();
        obs_pt();
        check_val("post_rst_ack", halt_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
